// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 encodings for
// loads/stores, the FSM state type and a legality helper for funct3.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // RV32I load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_MEM_BYTES_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;

    // Unsigned variants exist only for loads; 011/110/111 are never legal.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return is_store;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_req_if : request/response handshake between execute stage and LSU.
//   master = execute stage (drives req_*), slave = load_store_unit.
//   req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata;
//   resp_valid (one-cycle pulse), resp_rdata, resp_err.
// lsu_mem_if : byte-addressed data memory port.
//   master = load_store_unit, slave = memory.
//   mem_write/mem_read strobes, mem_addr, mem_wdata; mem_rdata returns
//   {m[a+3], m[a+2], m[a+1], m[a]} combinationally.
// -----------------------------------------------------------------------------
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_write, mem_read, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_write, mem_read, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load extender: selects the low byte/halfword/word of the
// memory word and sign- or zero-extends it according to funct3.
//   funct3_i : load funct3 (B, H, W, BU, HU)
//   word_i   : raw memory word, byte 0 in [7:0]
//   data_o   : extended 32-bit load result (0 for non-load encodings)
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves data_o
        // unassigned; otherwise synthesis infers a latch.
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{word_i[7]}}, word_i[7:0]};
            F3_H:    data_o = {{16{word_i[15]}}, word_i[15:0]};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, word_i[7:0]};
            F3_HU:   data_o = {16'h0, word_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Core-side initiator for a byte-addressed data memory. Accepts one RV32I
// load/store at a time, performs sub-word stores by read-modify-write (the
// memory always writes 4 bytes) and returns a one-cycle response pulse.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset; also blocks memory strobes at once
//   req  : lsu_req_if.slave  - request handshake and response
//   mem  : lsu_mem_if.master - memory port
// Latency from accept in cycle n to resp_valid: error n+1, load/SW n+2,
// SB/SH n+3.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    // Highest legal word start address; 32-bit unsigned compare, no wrap.
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_t  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_ext;

    logic        mem_write_d;
    logic        mem_read_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_wdata_d;

    assign accept  = req.req_valid & req_ready_q;
    assign req_err = (req.req_addr > LAST_ADDR) | f3_illegal(req.req_we, req.req_funct3);

    lsu_load_align u_load_align (
        .funct3_i (funct3_q),
        .word_i   (mem.mem_rdata),
        .data_o   (load_ext)
    );

    // Single FSM block; all response outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req.req_we;
                        funct3_q    <= req.req_funct3;
                        addr_q      <= req.req_addr;
                        wdata_q     <= req.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            // Errors skip the memory entirely.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (!req.req_we) begin
                            state_q <= LOAD;
                        end else if (req.req_funct3 == F3_W) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? '0 : load_ext;
                end
                RMW_RD: begin
                    // Keep the untouched upper bytes of the current word.
                    merge_q <= (funct3_q == F3_B) ? {mem.mem_rdata[31:8],  wdata_q[7:0]}
                                                  : {mem.mem_rdata[31:16], wdata_q[15:0]};
                    state_q <= WRITE;
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    // Memory strobes decode the current state and are forced low while rst
    // is high, so a reset arriving mid-operation can never issue a write.
    always_comb begin
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (!rst) begin
            case (state_q)
                LOAD, RMW_RD: begin
                    mem_read_d = 1'b1;
                    mem_addr_d = addr_q;
                end
                WRITE: begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = (funct3_q == F3_W) ? wdata_q : merge_q;
                end
                default: ;
            endcase
        end
    end

    assign req.req_ready  = req_ready_q;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = resp_rdata_q;

    assign mem.mem_write  = mem_write_d;
    assign mem.mem_read   = mem_read_d;
    assign mem.mem_addr   = mem_addr_d;
    assign mem.mem_wdata  = mem_wdata_d;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: a byte-array memory model serves the DUT's memory
// port, and a reference byte image plus access rules predicts every response,
// latency, strobe count and the resulting memory contents.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int          MEM_BYTES = 1024;
    localparam logic [31:0] LAST      = 32'(MEM_BYTES - 4);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if req_bus ();
    lsu_mem_if mem_bus ();

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus),
        .mem (mem_bus)
    );

    // ---------------- memory model (the DUT's environment) ----------------
    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       mem_loaded = 1'b0;
    logic [9:0] ma;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h10:    return 8'h11;
            'h11:    return 8'h22;
            'h12:    return 8'h33;
            'h13:    return 8'h80;
            default: return 8'((i * 37 + 5) ^ (i >> 3));
        endcase
    endfunction

    assign ma = mem_bus.mem_addr[9:0];
    assign mem_bus.mem_rdata = (mem_bus.mem_addr <= LAST)
                             ? {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]}
                             : 32'h0;

    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
            mem_loaded <= 1'b1;
        end else if (mem_bus.mem_write && mem_bus.mem_addr <= LAST) begin
            for (int b = 0; b < 4; b++) mem[ma + 10'(b)] <= mem_bus.mem_wdata[8*b +: 8];
        end
    end

    // ---------------- strobe monitor ----------------
    int cyc = 0;
    int rd_total = 0;
    int wr_total = 0;
    int last_wr_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_bus.mem_read)  rd_total = rd_total + 1;
        if (mem_bus.mem_write) begin
            wr_total    = wr_total + 1;
            last_wr_cyc = cyc;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return !legal || (addr > 32'(MEM_BYTES - 4));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int     n = access_bytes(f3);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[addr[9:0] + 10'(i)]) << (8 * i));
        // Signed narrow loads: interpret as two's complement of n bytes.
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic compare_image(input string tag);
        int diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, 32'(diffs), 32'd0);
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input string tag, output logic [31:0] got);
        int          rd0, wr0, acc, lat, n;
        int          exp_lat, exp_rd, exp_wr, exp_wlat;
        logic        err, exp_err;
        logic [31:0] exp_rdata;

        n         = access_bytes(f3);
        exp_err   = ref_err(we, f3, addr);
        exp_rdata = (exp_err || we) ? 32'h0 : ref_load(f3, addr);
        exp_lat   = exp_err ? 1 : (!we ? 2 : (n == 4 ? 2 : 3));
        exp_rd    = exp_err ? 0 : (!we ? 1 : (n == 4 ? 0 : 1));
        exp_wr    = (!exp_err && we) ? 1 : 0;
        exp_wlat  = (n == 4) ? 1 : 2;

        @(posedge clk); #1;
        check({tag, "_ready"}, 32'(req_bus.req_ready), 32'd1);
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = we;
        req_bus.req_funct3 = f3;
        req_bus.req_addr   = addr;
        req_bus.req_wdata  = wd;
        rd0 = rd_total;
        wr0 = wr_total;
        acc = cyc;
        @(posedge clk); #1;
        req_bus.req_valid = 1'b0;

        lat = 0;
        got = 32'hx;
        err = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (req_bus.resp_valid) begin
                lat = k;
                got = req_bus.resp_rdata;
                err = req_bus.resp_err;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, got, exp_rdata);
        check({tag, "_err"}, 32'(err), 32'(exp_err));

        // Response must be a single-cycle pulse.
        @(negedge clk);
        check({tag, "_pulse"}, 32'(req_bus.resp_valid), 32'd0);
        check({tag, "_reads"}, 32'(rd_total - rd0), 32'(exp_rd));
        check({tag, "_writes"}, 32'(wr_total - wr0), 32'(exp_wr));
        if (exp_wr == 1) check({tag, "_wr_cycle"}, 32'(last_wr_cyc - acc), 32'(exp_wlat));

        if (exp_wr == 1)
            for (int i = 0; i < n; i++) ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
        compare_image({tag, "_image"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] got;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          acc_wr;

        req_bus.req_valid  = 1'b0;
        req_bus.req_we     = 1'b0;
        req_bus.req_funct3 = 3'd0;
        req_bus.req_addr   = 32'd0;
        req_bus.req_wdata  = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", 32'(mem_bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(req_bus.req_ready), 32'd1);
        check("reset_resp_valid", 32'(req_bus.resp_valid), 32'd0);
        check("reset_resp_rdata", req_bus.resp_rdata, 32'd0);
        check("reset_resp_err", 32'(req_bus.resp_err), 32'd0);
        check("reset_mem_addr", mem_bus.mem_addr, 32'd0);
        compare_image("preload_image");

        // Directed loads from the preloaded word 11,22,33,80 at 0x10
        run_req(1'b0, F3_W,  32'h10, 32'h0, "lw_10", got);
        check("lw_10_const", got, 32'h80332211);
        run_req(1'b0, F3_B,  32'h13, 32'h0, "lb_13", got);
        check("lb_13_const", got, 32'hFFFFFF80);
        run_req(1'b0, F3_BU, 32'h13, 32'h0, "lbu_13", got);
        check("lbu_13_const", got, 32'h00000080);
        run_req(1'b0, F3_H,  32'h12, 32'h0, "lh_12", got);
        check("lh_12_const", got, 32'hFFFF8033);
        run_req(1'b0, F3_HU, 32'h12, 32'h0, "lhu_12", got);
        check("lhu_12_const", got, 32'h00008033);

        // Directed stores
        run_req(1'b1, F3_B, 32'h11, 32'h000000AB, "sb_11", got);
        check("sb_m10", 32'(mem['h10]), 32'h11);
        check("sb_m11", 32'(mem['h11]), 32'hAB);
        check("sb_m12", 32'(mem['h12]), 32'h33);
        check("sb_m13", 32'(mem['h13]), 32'h80);
        run_req(1'b1, F3_H, 32'h20, 32'h1234ABCD, "sh_20", got);
        check("sh_m20", 32'(mem['h20]), 32'hCD);
        check("sh_m21", 32'(mem['h21]), 32'hAB);
        run_req(1'b1, F3_W, 32'h30, 32'hDEADBEEF, "sw_30", got);
        check("sw_m30_33", {mem['h33], mem['h32], mem['h31], mem['h30]}, 32'hDEADBEEF);

        // Boundary and error cases
        run_req(1'b0, F3_W,   32'h3FC, 32'h0, "lw_3fc_edge", got);
        run_req(1'b1, F3_W,   32'h3FC, 32'hCAFEF00D, "sw_3fc_edge", got);
        run_req(1'b0, F3_W,   32'h3FD, 32'h0, "lw_3fd_err", got);
        run_req(1'b0, 3'b011, 32'h10,  32'h0, "f3_011_err", got);
        run_req(1'b1, F3_BU,  32'h10,  32'h55, "sbu_err", got);
        run_req(1'b1, F3_HU,  32'h10,  32'h55, "shu_err", got);
        run_req(1'b0, F3_B,   32'hFFFFFFFF, 32'h0, "lb_wrap_err", got);

        // Reset during RMW_RD of an SB: no write may ever reach memory
        @(posedge clk); #1;
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = 1'b1;
        req_bus.req_funct3 = F3_B;
        req_bus.req_addr   = 32'h40;
        req_bus.req_wdata  = 32'h0000005A;
        acc_wr = wr_total;
        @(posedge clk); #1;
        req_bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_rst_mem_read", 32'(mem_bus.mem_read), 32'd0);
        check("abort_rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(req_bus.req_ready), 32'd1);
        check("abort_resp_valid", 32'(req_bus.resp_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_writes", 32'(wr_total - acc_wr), 32'd0);
        compare_image("abort_image");

        // Randomized transactions against the reference model
        for (int t = 0; t < 80; t++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                7:       r_addr = 32'(1017 + $urandom_range(0, 6));
                8:       r_addr = 32'($urandom_range(32'h10, 32'h44));
                9:       r_addr = $urandom;
                default: r_addr = 32'($urandom_range(0, MEM_BYTES - 1));
            endcase
            run_req(r_we, r_f3, r_addr, $urandom, $sformatf("rnd%0d", t), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
